div: RTL and testbench

Multi-cycle 32-bit integer divider that computes a quotient and remainder for the EX stage and raises the stall request that the pipeline controller turns into the `stall[5:0]` vector consumed by the pipeline registers. The divider produces stalls, while the IF/ID, ID/EX and later stage registers consume them. EX holds `start_i` high and freezes the front of the pipeline until `ready_o` returns. The result feeds the HI/LO write path: HI gets the remainder, LO gets the quotient.

---
 rtl/div_pkg.sv | 25 ++
 rtl/div_if.sv | 23 ++
 rtl/div.sv | 139 +++++++++++++
 tb/tb_div.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared widths, handshake constants and FSM encoding for the EX-stage divider.
package div_pkg;

  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [5:0] DIV_ITERS = 6'd32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  function automatic logic [REG_BUS-1:0] neg32(input logic [REG_BUS-1:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/div_if.sv
// Request/result bundle between EX (master) and the divider (slave).
interface div_if;
  import div_pkg::*;

  logic                      signed_div_i;
  logic [REG_BUS-1:0]        opdata1_i;
  logic [REG_BUS-1:0]        opdata2_i;
  logic                      start_i;
  logic                      annul_i;
  logic [DOUBLE_REG_BUS-1:0] result_o;
  logic                      ready_o;
  logic                      stallreq_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider: one quotient bit per cycle, result {rem, quot}.
//
// state       | meaning
// DIV_FREE    | idle, accepts start_i when annul_i is low
// DIV_BY_ZERO | divisor was zero, result forced to 0 next edge
// DIV_ON      | iterating, cnt counts quotient bits produced
// DIV_END     | result held until start_i drops or annul_i
module div
  import div_pkg::*;
(
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);

  div_state_e          r_state;
  div_state_e          w_state_nxt;
  logic [5:0]          r_cnt;
  logic [64:0]         r_work;
  logic [REG_BUS-1:0]  r_divisor;
  logic                r_q_neg;
  logic                r_r_neg;
  logic [63:0]         r_result;
  logic                r_ready;

  logic                w_accept;
  logic                w_iter;
  logic                w_finish;
  logic                w_zero;
  logic                w_clear;
  logic [33:0]         w_trial;
  logic [64:0]         w_work_nxt;
  logic [REG_BUS-1:0]  w_op1_mag;
  logic [REG_BUS-1:0]  w_op2_mag;
  logic [REG_BUS-1:0]  w_q_fin;
  logic [REG_BUS-1:0]  w_r_fin;

  assign w_op1_mag = (bus.signed_div_i && bus.opdata1_i[31]) ? neg32(bus.opdata1_i) : bus.opdata1_i;
  assign w_op2_mag = (bus.signed_div_i && bus.opdata2_i[31]) ? neg32(bus.opdata2_i) : bus.opdata2_i;

  // r_work[64:31] is the partial remainder already shifted left by one
  assign w_trial    = r_work[64:31] - {2'b00, r_divisor};
  assign w_work_nxt = w_trial[33] ? {r_work[63:0], 1'b0}
                                  : {w_trial[32:0], r_work[30:0], 1'b1};

  assign w_q_fin = r_q_neg ? neg32(r_work[31:0])  : r_work[31:0];
  assign w_r_fin = r_r_neg ? neg32(r_work[63:32]) : r_work[63:32];

  always_ff @(posedge clk) begin
    if (rst) r_state <= DIV_FREE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_iter      = 1'b0;
    w_finish    = 1'b0;
    w_zero      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      DIV_FREE: begin
        if (bus.start_i == DIV_START && !bus.annul_i) begin
          w_accept    = 1'b1;
          w_state_nxt = (bus.opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
        end
      end
      DIV_BY_ZERO: begin
        if (bus.annul_i) begin
          w_clear     = 1'b1;
          w_state_nxt = DIV_FREE;
        end else begin
          w_zero      = 1'b1;
          w_state_nxt = DIV_END;
        end
      end
      DIV_ON: begin
        // annul wins over completion on the same edge
        if (bus.annul_i) begin
          w_clear     = 1'b1;
          w_state_nxt = DIV_FREE;
        end else if (r_cnt == DIV_ITERS) begin
          w_finish    = 1'b1;
          w_state_nxt = DIV_END;
        end else begin
          w_iter      = 1'b1;
        end
      end
      DIV_END: begin
        if (bus.annul_i || bus.start_i == DIV_STOP) begin
          w_clear     = 1'b1;
          w_state_nxt = DIV_FREE;
        end
      end
      default: w_state_nxt = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_result  <= '0;
      r_ready   <= DIV_RESULT_NOT_READY;
    end else begin
      if (w_accept) begin
        r_cnt     <= '0;
        r_work    <= {33'd0, w_op1_mag};
        r_divisor <= w_op2_mag;
        r_q_neg   <= bus.signed_div_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
        r_r_neg   <= bus.signed_div_i && bus.opdata1_i[31];
      end
      if (w_iter) begin
        r_work <= w_work_nxt;
        r_cnt  <= r_cnt + 6'd1;
      end
      if (w_finish) begin
        r_result <= {w_r_fin, w_q_fin};
        r_ready  <= DIV_RESULT_READY;
      end
      if (w_zero) begin
        r_result <= '0;
        r_ready  <= DIV_RESULT_READY;
      end
      if (w_clear) begin
        r_result <= '0;
        r_ready  <= DIV_RESULT_NOT_READY;
      end
    end
  end

  assign bus.result_o   = r_result;
  assign bus.ready_o    = r_ready;
  assign bus.stallreq_o = bus.start_i & ~bus.annul_i & ~r_ready;

endmodule

// File: tb/tb_div.sv
// Directed checks of the divider: latency, signed/unsigned results, divide-by-zero, annul and reset.
module tb_div;
  import div_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  div_if bus ();

  div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept at the next edge, wait for ready, check latency/stall/result, then release.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int n;
    logic stall_ok;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    tick();
    bus.opdata1_i = ~a;
    bus.opdata2_i = b ^ 32'h5A5A_0003;
    n = 0;
    stall_ok = 1'b1;
    while (!bus.ready_o && n < 100) begin
      if (bus.stallreq_o !== 1'b1) stall_ok = 1'b0;
      tick();
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(exp_lat));
    chk({tag, " stall_before_ready"}, {63'd0, stall_ok}, 64'd1);
    chk({tag, " result"}, bus.result_o, exp);
    chk({tag, " stall_at_ready"}, {63'd0, bus.stallreq_o}, 64'd0);
    tick();
    chk({tag, " held"}, bus.result_o, exp);
    bus.start_i = 1'b0;
    tick();
    chk({tag, " ready_clr"}, {63'd0, bus.ready_o}, 64'd0);
    chk({tag, " result_clr"}, bus.result_o, 64'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset ready", {63'd0, bus.ready_o}, 64'd0);
    chk("reset result", bus.result_o, 64'd0);
    chk("reset stall", {63'd0, bus.stallreq_o}, 64'd0);

    run_div("u100_7",   1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 33);
    run_div("s-7_2",    1'b1, 32'hFFFFFFF9,  32'd2,         64'hFFFFFFFF_FFFFFFFD, 33);
    run_div("s7_-2",    1'b1, 32'd7,         32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 33);
    run_div("u_fff9_2", 1'b0, 32'hFFFFFFF9,  32'd2,         64'h00000001_7FFFFFFC, 33);
    run_div("div0",     1'b0, 32'h12345678,  32'd0,         64'd0,                 1);
    run_div("s_ovf",    1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 33);
    run_div("u_max_1",  1'b0, 32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF, 33);

    // start with annul in idle is refused
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    chk("annul_idle stall", {63'd0, bus.stallreq_o}, 64'd0);
    tick();
    tick();
    chk("annul_idle state", {62'd0, dut.r_state}, {62'd0, DIV_FREE});
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    tick();

    // annul at iteration 10
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i = 1'b1;
    tick();
    for (int i = 1; i < 10; i++) tick();
    bus.annul_i = 1'b1;
    tick();
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    chk("annul_mid ready", {63'd0, bus.ready_o}, 64'd0);
    chk("annul_mid result", bus.result_o, 64'd0);
    chk("annul_mid state", {62'd0, dut.r_state}, {62'd0, DIV_FREE});
    tick();
    run_div("u9_4", 1'b0, 32'd9, 32'd4, 64'h00000001_00000002, 33);

    // start dropped mid-iteration: result pulses for one cycle
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i = 1'b1;
    tick();
    for (int i = 1; i < 5; i++) tick();
    bus.start_i = 1'b0;
    for (int i = 5; i < 33; i++) tick();
    chk("drop_start notyet", {63'd0, bus.ready_o}, 64'd0);
    tick();
    chk("drop_start ready", {63'd0, bus.ready_o}, 64'd1);
    chk("drop_start result", bus.result_o, 64'h00000002_0000000E);
    tick();
    chk("drop_start clr", {63'd0, bus.ready_o}, 64'd0);

    // reset mid-iteration
    bus.start_i = 1'b1;
    tick();
    for (int i = 1; i < 12; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.start_i = 1'b0;
    chk("rst_mid ready", {63'd0, bus.ready_o}, 64'd0);
    chk("rst_mid result", bus.result_o, 64'd0);
    chk("rst_mid state", {62'd0, dut.r_state}, {62'd0, DIV_FREE});
    tick();
    run_div("after_rst", 1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
